uart_infer_ctrl: RTL

Frame sequencer between the UART receiver/transmitter and the network processor. It collects `FRAME_LEN` bytes from `uart_rx` into the processor's external memory, pulses `net_start`, and waits for `net_done`. It then sends one ASCII result byte through `uart_tx` and returns to idle. It generalises the fixed 784-byte / 4-bit flow with parametric frame length and result width, overrun detection, an error counter and an optional inter-byte timeout.

---
 rtl/uart_infer_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_infer_ctrl.sv
// uart_infer_ctrl
// ---------------
// Frame sequencer between a UART receiver/transmitter and a network
// processor. It collects FRAME_LEN bytes from uart_rx into the processor's
// external memory, pulses net_start, waits for net_done, returns one ASCII
// result byte through uart_tx and goes back to idle.
//
// Optional feature macro: UART_IC_TIMEOUT_EN
//   defined   -> a frame stalled for TIMEOUT_CYC cycles without a byte is
//                aborted and counted as an error.
//   undefined -> LOAD waits forever; err_cnt counts overruns only.
//
// Ports
//   clk          in   clock, everything on posedge
//   rst          in   synchronous active-high reset
//   rx_ready     in   level from uart_rx, rising edge = rx_data valid
//   rx_data      in   [7:0] received byte
//   mem_rst      out  one-cycle pulse, resets the network's write address
//   mem_we       out  one-cycle write strobe
//   mem_wdata    out  [7:0] byte to write (valid with mem_we)
//   net_start    out  one-cycle start pulse
//   net_done     in   level from the network, rising edge = net_idx valid
//   net_idx      in   [IDX_W-1:0] argmax index
//   tx_rq        out  one-cycle transmit request
//   tx_data      out  [7:0] byte to transmit (RESP_BASE + net_idx)
//   tx_busy      in   transmitter busy
//   last_result  out  [IDX_W-1:0] last index received
//   err_cnt      out  [7:0] saturating error counter
//   busy         out  high whenever the previous state was not IDLE
module uart_infer_ctrl #(
  parameter int         FRAME_LEN   = 784,
  parameter int         IDX_W       = 4,
  parameter logic [7:0] RESP_BASE   = 8'h30,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_ready,
  input  logic [7:0]       rx_data,
  output logic             mem_rst,
  output logic             mem_we,
  output logic [7:0]       mem_wdata,
  output logic             net_start,
  input  logic             net_done,
  input  logic [IDX_W-1:0] net_idx,
  output logic             tx_rq,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic [IDX_W-1:0] last_result,
  output logic [7:0]       err_cnt,
  output logic             busy
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_SEND} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rx_old_q, done_old_q;
  logic             mem_rst_q, wr_pend_q, mem_we_q;
  logic [7:0]       wr_data_q, mem_wdata_q;
  logic             start_p1_q, start_p2_q, net_start_q;
  logic             tx_rq_q, busy_q;
  logic [7:0]       tx_data_q, err_cnt_q;
  logic [IDX_W-1:0] last_result_q;

  logic       rx_edge, done_edge;
  logic       first_byte, byte_accept, frame_full, done_cap, tx_fire, err_inc;
  logic [7:0] idx_ext;

  assign rx_edge   = rx_ready & ~rx_old_q;
  assign done_edge = net_done & ~done_old_q;
  assign idx_ext   = 8'(net_idx);

`ifdef UART_IC_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_byte  = 1'b0;
    byte_accept = 1'b0;
    frame_full  = 1'b0;
    done_cap    = 1'b0;
    tx_fire     = 1'b0;
    err_inc     = 1'b0;
`ifdef UART_IC_TIMEOUT_EN
    idle_d      = '0;
`endif
    case (state_q)
      S_IDLE: begin
        // FRAME_LEN >= 2, so the first byte can never complete a frame.
        if (rx_edge) begin
          byte_accept = 1'b1;
          first_byte  = 1'b1;
          cnt_d       = CNT_W'(1);
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (rx_edge) begin
          byte_accept = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_d == CNT_LAST) begin
            frame_full = 1'b1;
            state_d    = S_RUN;
          end
        end
`ifdef UART_IC_TIMEOUT_EN
        else if (idle_q == TO_LAST) begin
          // Stalled frame: drop it, nothing has been started yet.
          err_inc = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
`endif
      end
      S_RUN: begin
        if (done_edge) begin
          done_cap = 1'b1;
          state_d  = S_SEND;
        end
        if (rx_edge) err_inc = 1'b1;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_fire = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        if (rx_edge) err_inc = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rx_old_q      <= 1'b1;  // a level already high at release is not a byte
      done_old_q    <= 1'b0;
      mem_rst_q     <= 1'b0;
      wr_pend_q     <= 1'b0;
      wr_data_q     <= 8'h00;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 8'h00;
      start_p1_q    <= 1'b0;
      start_p2_q    <= 1'b0;
      net_start_q   <= 1'b0;
      tx_rq_q       <= 1'b0;
      tx_data_q     <= 8'h00;
      last_result_q <= '1;
      err_cnt_q     <= 8'h00;
      busy_q        <= 1'b0;
`ifdef UART_IC_TIMEOUT_EN
      idle_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_old_q    <= rx_ready;
      done_old_q  <= net_done;
      mem_rst_q   <= first_byte;
      // One staging register puts the write two cycles after the edge.
      wr_pend_q   <= byte_accept;
      if (byte_accept) wr_data_q <= rx_data;
      mem_we_q    <= wr_pend_q;
      if (wr_pend_q) mem_wdata_q <= wr_data_q;
      // Start lands one cycle after the last write.
      start_p1_q  <= frame_full;
      start_p2_q  <= start_p1_q;
      net_start_q <= start_p2_q;
      tx_rq_q     <= tx_fire;
      if (done_cap) begin
        last_result_q <= net_idx;
        tx_data_q     <= RESP_BASE + idx_ext;
      end
      if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      busy_q      <= (state_q != S_IDLE);
`ifdef UART_IC_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign mem_rst     = mem_rst_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign net_start   = net_start_q;
  assign tx_rq       = tx_rq_q;
  assign tx_data     = tx_data_q;
  assign last_result = last_result_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = busy_q;

endmodule
